dmem_scanner: RTL and testbench
===============================

DMEM_SCANNER -- requirements
Module: dmem_scanner

Interface
REQ-001 The module SHALL have parameter REFRESH_DIV, default 50000, clock cycles per digit period (minimum 2).
REQ-002 The module SHALL have parameter SCROLL_TICKS, default 2000, digit periods per auto-scroll address advance (minimum 1).
REQ-003 Port: clock  input  1  single system clock; all state SHALL be clocked on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset; all state SHALL clear while reset is low, regardless of clock.
REQ-005 Port: datamem_bus  input  128  the 16 data-memory bytes; byte i SHALL be at bits [8i+7:8i].
REQ-006 Port: auto_scroll  input  1  1 = address advances automatically, 0 = manual stepping.
REQ-007 Port: step  input  1  raw, asynchronous push-button; a rising edge advances the address in manual mode.
REQ-008 Port: seg  output  7  active-low segments, seg[0] = a through seg[6] = g.
REQ-009 Port: an  output  4  active-low digit enables; exactly one bit SHALL be low outside reset.
REQ-010 Port: shown_addr  output  4  address of the byte currently latched for display.

Function
REQ-011 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; a refresh tick SHALL occur on the cycle it equals REFRESH_DIV-1.
REQ-012 Digit index SHALL advance 0→1→2→3→0 on each refresh tick.
REQ-013 an and seg SHALL be registered and SHALL reflect the new digit index on the first cycle after the tick.
REQ-014 Digit 0 SHALL show the low nibble of the snapshot, digit 1 the high nibble, digit 2 shown_addr, and digit 3 SHALL be blank (seg = 7'h7F) with an[3] still low during its period.
REQ-015 Hex encoding SHALL be standard active-low, e.g. 0 = 7'h40, 8 = 7'h00, A = 7'h08, F = 7'h0E.
REQ-016 Snapshot register SHALL latch datamem_bus byte[sel_addr], and shown_addr SHALL latch sel_addr, only on the refresh tick where the digit index wraps 3→0; values SHALL be frame-stable, with no tearing.
REQ-017 step SHALL pass through a 2-flop synchronizer followed by rising-edge detection, giving 3 cycles of latency from input edge to step pulse.
REQ-018 Manual mode: each step pulse SHALL increment sel_addr modulo 16 (15→0).
REQ-019 Auto mode: step pulses SHALL be ignored; a scroll counter SHALL count refresh ticks and increment sel_addr modulo 16 on every SCROLL_TICKS-th tick.
REQ-020 A transition of auto_scroll SHALL clear the scroll counter and SHALL leave sel_addr unchanged.
REQ-021 A step pulse coinciding with the auto_scroll 1→0 cycle SHALL be ignored.
REQ-022 A changed sel_addr SHALL appear on shown_addr and the digits only at the next frame snapshot, with latency of at most 4×REFRESH_DIV+1 cycles.

Reset
REQ-023 While reset is low: seg = 7'h7F, an = 4'hF, shown_addr = 0, snapshot = 0, sel_addr = 0, and all counters and synchronizer flops = 0.
REQ-024 After reset release, the first non-blank output SHALL appear one cycle after the first refresh tick, on digit 1 (an = 4'b1101).
REQ-025 Reset asserted mid-frame SHALL blank the outputs immediately, asynchronously.

Structure
REQ-026 A shared package SHALL hold the 16-entry seven-segment constant table, the blank pattern, and the digit-enable patterns.
REQ-027 Hex-to-segment decoding SHALL be a combinational sub-module named hex7seg; all sequencing SHALL reside in dmem_scanner.

Verification (REFRESH_DIV = 4, SCROLL_TICKS = 2)
REQ-028 Reset release, bus byte0 = 8'h3C -> an sequence 1101, 1011, 0111, 1110 at 4-cycle spacing; after the first 3→0 wrap, digits show C, 3, 0, blank.
REQ-029 Manual mode: 17 debounced step edges -> shown_addr ends at 1 (wrap-around verified), and each step change is seen only at a frame boundary.
REQ-030 Change byte5 mid-frame while displaying address 5 -> no segment change until the next 3→0 wrap, then the new value is shown.
REQ-031 Auto mode, step toggled continuously -> shown_addr advances exactly every 2 ticks (0,1,2...), and step has no effect.
REQ-032 Assert reset during digit 2 -> same cycle seg = 7'h7F, an = 4'hF; after release, state is identical to the state after first reset.
REQ-033 One-cycle glitch on step shorter than the clock period -> at most one increment, never two.

Source files
------------

// File: rtl/dmem_scanner_pkg.sv
// -----------------------------------------------------------------------------
// dmem_scanner_pkg
//   Shared constants and types for the data-memory display scanner:
//     - SEG_TBL   : 16-entry active-low seven-segment table (bit 0 = a .. bit 6 = g)
//     - SEG_BLANK : all segments off
//     - AN_PAT    : active-low digit-enable pattern per digit index
//     - AN_OFF    : all digits disabled
//     - digit_e   : digit index / display-role encoding
//     - next_digit: 0->1->2->3->0 sequencing helper
// -----------------------------------------------------------------------------
package dmem_scanner_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int NUM_BYTES  = 16;

    // Each digit index has a fixed role in the frame.
    typedef enum logic [1:0] {
        DIG_LO    = 2'd0,   // low nibble of the snapshot byte
        DIG_HI    = 2'd1,   // high nibble of the snapshot byte
        DIG_ADDR  = 2'd2,   // address of the snapshot byte
        DIG_BLANK = 2'd3    // dark digit, enable still driven
    } digit_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Active-low segments, index = hex value.
    localparam logic [6:0] SEG_TBL [NUM_BYTES] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Active-low enables, exactly one digit low, index = digit index.
    localparam logic [3:0] AN_PAT [NUM_DIGITS] = '{
        4'b1110, 4'b1101, 4'b1011, 4'b0111
    };

    function automatic digit_e next_digit(input digit_e d);
        return digit_e'(d + 2'd1);
    endfunction

endpackage

// File: rtl/hex7seg.sv
// -----------------------------------------------------------------------------
// hex7seg
//   Combinational hex-to-seven-segment decoder (active-low outputs).
//   Ports:
//     hex [3:0] : nibble to display
//     seg [6:0] : active-low segments, seg[0] = a .. seg[6] = g
// -----------------------------------------------------------------------------
module hex7seg
    import dmem_scanner_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TBL[hex];

endmodule

// File: rtl/dmem_scanner.sv
// -----------------------------------------------------------------------------
// dmem_scanner
//   Multiplexed four-digit display of one byte of a 16-byte data memory.
//   Each frame (four digit periods) shows: digit 0 = low nibble, digit 1 =
//   high nibble, digit 2 = byte address, digit 3 = blank. The displayed byte
//   and its address are captured once per frame so a frame never mixes old
//   and new data. The address either auto-scrolls or steps on a push-button.
//
//   Parameters:
//     REFRESH_DIV  : clock cycles per digit period (>= 2)
//     SCROLL_TICKS : digit periods per auto-scroll advance (>= 1)
//   Ports:
//     clock        : system clock, rising edge
//     reset        : asynchronous active-low reset
//     datamem_bus  : 16 bytes, byte i at [8i+7:8i]
//     auto_scroll  : 1 = auto address advance, 0 = manual stepping
//     step         : raw asynchronous push-button
//     seg          : active-low segments (registered)
//     an           : active-low digit enables (registered)
//     shown_addr   : address of the byte latched for the current frame
// -----------------------------------------------------------------------------
module dmem_scanner
    import dmem_scanner_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int SCROLL_TICKS = 2000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [127:0] datamem_bus,
    input  logic         auto_scroll,
    input  logic         step,
    output logic [6:0]   seg,
    output logic [3:0]   an,
    output logic [3:0]   shown_addr
);

    localparam int RW = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
    localparam int SW = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;

    // -------------------------------------------------------------------------
    // Refresh timing
    // -------------------------------------------------------------------------
    logic [RW-1:0] refresh_cnt;
    logic          tick;
    digit_e        digit;
    digit_e        digit_nxt;
    logic          wrap;

    assign tick      = (refresh_cnt == RW'(REFRESH_DIV - 1));
    assign digit_nxt = next_digit(digit);
    assign wrap      = tick && (digit == DIG_BLANK);

    // -------------------------------------------------------------------------
    // Frame snapshot source
    // -------------------------------------------------------------------------
    logic [NUM_BYTES-1:0][7:0] mem_bytes;
    logic [3:0]                sel_addr;
    logic [7:0]                snapshot;
    logic [7:0]                snap_nxt;
    logic [3:0]                shown_nxt;

    assign mem_bytes = datamem_bus;

    // The snapshot taken on the wrap tick is decoded on that same tick, so
    // digit 0 of a new frame already shows the new byte.
    assign snap_nxt  = wrap ? mem_bytes[sel_addr] : snapshot;
    assign shown_nxt = wrap ? sel_addr            : shown_addr;

    // -------------------------------------------------------------------------
    // Nibble selection for the digit about to be driven
    // -------------------------------------------------------------------------
    logic [3:0] nibble;
    logic [6:0] hex_seg;

    always_comb begin
        nibble = 4'h0;
        unique case (digit_nxt)
            DIG_LO:   nibble = snap_nxt[3:0];
            DIG_HI:   nibble = snap_nxt[7:4];
            DIG_ADDR: nibble = shown_nxt;
            default:  nibble = 4'h0;
        endcase
    end

    hex7seg u_hex7seg (
        .hex (nibble),
        .seg (hex_seg)
    );

    // -------------------------------------------------------------------------
    // Digit scan: counter, digit index, snapshot and registered outputs.
    // Outputs stay blank after reset until the first tick, whose first lit
    // digit is digit 1.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            refresh_cnt <= '0;
            digit       <= DIG_LO;
            snapshot    <= 8'h00;
            shown_addr  <= 4'h0;
            seg         <= SEG_BLANK;
            an          <= AN_OFF;
        end else begin
            refresh_cnt <= tick ? '0 : refresh_cnt + 1'b1;
            if (tick) begin
                digit <= digit_nxt;
                an    <= AN_PAT[digit_nxt];
                seg   <= (digit_nxt == DIG_BLANK) ? SEG_BLANK : hex_seg;
            end
            if (wrap) begin
                snapshot   <= snap_nxt;
                shown_addr <= shown_nxt;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Step synchronizer and edge detect. step_s1/step_s2 resolve
    // metastability; step_s3 holds the previous synchronized level. The
    // pulse is registered so it is a clean single-cycle strobe.
    // -------------------------------------------------------------------------
    logic step_s1, step_s2, step_s3;
    logic step_pulse;

    // -------------------------------------------------------------------------
    // Address selection. Any change of auto_scroll is handled first: it
    // restarts the scroll count and swallows a coincident step pulse, so the
    // address never moves on a mode change.
    // -------------------------------------------------------------------------
    logic          auto_q;
    logic [SW-1:0] scroll_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            step_s1    <= 1'b0;
            step_s2    <= 1'b0;
            step_s3    <= 1'b0;
            step_pulse <= 1'b0;
            auto_q     <= 1'b0;
            scroll_cnt <= '0;
            sel_addr   <= 4'h0;
        end else begin
            step_s1    <= step;
            step_s2    <= step_s1;
            step_s3    <= step_s2;
            step_pulse <= step_s2 & ~step_s3;
            auto_q     <= auto_scroll;

            if (auto_scroll != auto_q) begin
                scroll_cnt <= '0;
            end else if (auto_scroll) begin
                if (tick) begin
                    if (scroll_cnt == SW'(SCROLL_TICKS - 1)) begin
                        scroll_cnt <= '0;
                        sel_addr   <= sel_addr + 4'd1;
                    end else begin
                        scroll_cnt <= scroll_cnt + 1'b1;
                    end
                end
            end else if (step_pulse) begin
                sel_addr <= sel_addr + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_scanner.sv
// -----------------------------------------------------------------------------
// tb_dmem_scanner
//   Self-checking bench for dmem_scanner with REFRESH_DIV = 4, SCROLL_TICKS = 2.
//   A reference model works from the elapsed edge count since reset: every
//   DIV-th edge is a digit tick, the digit is (ticks mod 4), and every fourth
//   tick starts a frame that captures the selected byte. Step edges seen at
//   the input take effect on the address three edges later.
// -----------------------------------------------------------------------------
module tb_dmem_scanner;

    localparam int DIV = 4;
    localparam int SCR = 2;
    localparam int FRAME = 4 * DIV;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [127:0] datamem_bus;
    logic         auto_scroll = 1'b0;
    logic         step = 1'b0;
    logic [6:0]   seg;
    logic [3:0]   an;
    logic [3:0]   shown_addr;

    int n_checks = 0;
    int n_errors = 0;

    dmem_scanner #(
        .REFRESH_DIV  (DIV),
        .SCROLL_TICKS (SCR)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .datamem_bus (datamem_bus),
        .auto_scroll (auto_scroll),
        .step        (step),
        .seg         (seg),
        .an          (an),
        .shown_addr  (shown_addr)
    );

    always #5 clock = ~clock;

    // Standard active-low hex font, gfedcba.
    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Expected outputs at edges 4,8,...,28 after reset release with byte0 = 3C.
    localparam logic [3:0] EXP_AN  [7] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110,
                                           4'b1101, 4'b1011, 4'b0111};
    localparam logic [6:0] EXP_SEG [7] = '{7'h40, 7'h40, 7'h7F, 7'h46,
                                           7'h30, 7'h40, 7'h7F};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    int         m_n = 0;          // edges since reset release
    int         m_aticks = 0;     // ticks counted since entering auto mode
    logic [3:0] m_sel = 4'h0;
    logic [3:0] m_shown = 4'h0;
    logic [7:0] m_snap = 8'h00;
    logic [6:0] m_seg = 7'h7F;
    logic [3:0] m_an = 4'hF;
    logic       m_prev_step = 1'b0;
    logic       m_prev_auto = 1'b0;
    int         m_pend [$];       // edge numbers at which a step lands

    task automatic model_clear();
        m_n = 0; m_aticks = 0; m_sel = 4'h0; m_shown = 4'h0; m_snap = 8'h00;
        m_seg = 7'h7F; m_an = 4'hF; m_prev_step = 1'b0; m_prev_auto = 1'b0;
        m_pend.delete();
    endtask

    task automatic model_edge();
        int  n;
        int  d;
        bit  is_tick;
        bit  pulse;
        n       = m_n + 1;
        is_tick = (n % DIV) == 0;
        pulse   = 1'b0;
        if (m_pend.size() > 0 && m_pend[0] == n) begin
            pulse = 1'b1;
            void'(m_pend.pop_front());
        end
        if (step && !m_prev_step) m_pend.push_back(n + 3);

        if (is_tick) begin
            d = (n / DIV) % 4;
            if (d == 0) begin
                m_snap  = datamem_bus[8*m_sel +: 8];
                m_shown = m_sel;
            end
            m_an = ~(4'b0001 << d);
            case (d)
                0:       m_seg = HEX[m_snap[3:0]];
                1:       m_seg = HEX[m_snap[7:4]];
                2:       m_seg = HEX[m_shown];
                default: m_seg = 7'h7F;
            endcase
        end

        if (auto_scroll != m_prev_auto) begin
            m_aticks = 0;
        end else if (auto_scroll) begin
            if (is_tick) begin
                m_aticks++;
                if (m_aticks % SCR == 0) m_sel = m_sel + 4'd1;
            end
        end else if (pulse) begin
            m_sel = m_sel + 4'd1;
        end

        m_prev_step = step;
        m_prev_auto = auto_scroll;
        m_n = n;
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) model_clear();
        else        model_edge();
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    task automatic cyc();
        @(negedge clock);
        chk("seg", {25'd0, seg}, {25'd0, m_seg});
        chk("an", {28'd0, an}, {28'd0, m_an});
        chk("shown_addr", {28'd0, shown_addr}, {28'd0, m_shown});
    endtask

    task automatic wait_phase(input int ph);
        for (int g = 0; g < 2 * FRAME && (m_n % FRAME) != ph; g++) cyc();
        chk("wait_phase", m_n % FRAME, ph);
    endtask

    task automatic push_step();
        step = 1'b1;
        repeat (3) cyc();
        step = 1'b0;
        repeat (3) cyc();
    endtask

    // Released from reset with byte0 = 3C, address 0, no stepping.
    task automatic first_frame_seq();
        for (int i = 1; i <= 28; i++) begin
            cyc();
            if (i == 3) chk("pre_tick_blank", {28'd0, an}, 32'hF);
            if (i % 4 == 0) begin
                chk("seq_an", {28'd0, an}, {28'd0, EXP_AN[i/4-1]});
                chk("seq_seg", {25'd0, seg}, {25'd0, EXP_SEG[i/4-1]});
            end
        end
    endtask

    initial begin
        logic [3:0] base;
        logic [3:0] dlt;
        logic [7:0] oldv;
        logic [7:0] newv;

        datamem_bus = {$urandom, $urandom, $urandom, $urandom};
        datamem_bus[7:0] = 8'h3C;

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_shown", {28'd0, shown_addr}, 32'h0);
        reset = 1'b1;
        first_frame_seq();

        // Manual: 17 steps wrap 0 -> 1
        for (int s = 0; s < 17; s++) push_step();
        repeat (40) cyc();
        chk("manual_wrap17", {28'd0, shown_addr}, 32'd1);

        // Move to address 5, then change byte5 mid-frame
        for (int s = 0; s < 4; s++) push_step();
        repeat (40) cyc();
        chk("manual_addr5", {28'd0, shown_addr}, 32'd5);
        wait_phase(6);
        oldv = datamem_bus[47:40];
        newv = oldv ^ 8'hA5;
        datamem_bus[47:40] = newv;
        cyc();
        chk("byte5_hold", {25'd0, seg}, {25'd0, HEX[oldv[7:4]]});
        wait_phase(0);
        chk("byte5_new", {25'd0, seg}, {25'd0, HEX[newv[3:0]]});

        // Glitch spanning a rising edge: one increment
        repeat (8) cyc();
        base = shown_addr;
        #4 step = 1'b1;
        #2 step = 1'b0;
        repeat (40) cyc();
        dlt = shown_addr - base;
        chk("glitch_on_edge", {28'd0, dlt}, 32'd1);

        // Glitch between edges: never sampled
        base = shown_addr;
        #1 step = 1'b1;
        #2 step = 1'b0;
        repeat (40) cyc();
        dlt = shown_addr - base;
        chk("glitch_off_edge", {28'd0, dlt}, 32'd0);

        // Auto mode with step toggling every cycle
        auto_scroll = 1'b1;
        repeat (40) begin cyc(); step = ~step; end
        for (int f = 0; f < 3; f++) begin
            while ((m_n % FRAME) != 1) begin cyc(); step = ~step; end
            base = shown_addr;
            repeat (FRAME) begin cyc(); step = ~step; end
            dlt = shown_addr - base;
            chk("auto_advance", {28'd0, dlt}, SCR == 2 ? 32'd2 : 32'd0);
        end
        step = 1'b0;
        auto_scroll = 1'b0;
        repeat (10) cyc();

        // Randomized mix
        for (int i = 0; i < 1500; i++) begin
            cyc();
            if ($urandom_range(0, 199) == 0) auto_scroll = ~auto_scroll;
            if ($urandom_range(0, 2) == 0) step = ~step;
            if ($urandom_range(0, 24) == 0)
                datamem_bus[8*$urandom_range(0, 15) +: 8] = 8'($urandom);
        end
        auto_scroll = 1'b0;
        step = 1'b0;
        repeat (8) cyc();

        // Reset during digit 2
        wait_phase(9);
        #2 reset = 1'b0;
        #1;
        chk("midrst_seg", {25'd0, seg}, 32'h7F);
        chk("midrst_an", {28'd0, an}, 32'hF);
        chk("midrst_shown", {28'd0, shown_addr}, 32'h0);
        datamem_bus[7:0] = 8'h3C;
        repeat (3) cyc();
        reset = 1'b1;
        first_frame_seq();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
